mem_access_unit: RTL and testbench

- Memory-side responder for the multicycle datapath. It sits between the memory-address select path (PC, exception vector, ALUOut, ALU register, register A) and the word-wide synchronous data memory.
- Accepts one load/store request at a time and performs byte, halfword or word access.
- Partial stores are done as read-modify-write. Load data is returned sign- or zero-extended.
- Misaligned or illegal accesses are flagged without touching memory.

---
 rtl/mem_access_unit_pkg.sv | 18 +
 rtl/mem_lane_unit.sv | 63 ++++++
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 tb/tb_mem_access_unit.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the memory access unit
package mem_access_unit_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        READ_WAIT = 2'b01,
        WRITE     = 2'b10,
        RESP      = 2'b11
    } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// rtl/mem_lane_unit.sv - byte-lane extraction, store merge and alignment check
module mem_lane_unit
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] merge_base_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merge_data_o,
    output logic        misaligned_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] byte_mask;
    logic [31:0] half_mask;

    assign byte_sh      = {addr_lo_i, 3'b000};
    assign half_sh      = {addr_lo_i[1], 4'b0000};
    assign byte_shifted = rdata_i >> byte_sh;
    assign byte_sel     = byte_shifted[7:0];
    assign half_sel     = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign byte_mask    = 32'h0000_00FF << byte_sh;
    assign half_mask    = 32'h0000_FFFF << half_sh;

    always_comb begin
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_HALF:    misaligned_o = addr_lo_i[0];
            SIZE_WORD:    misaligned_o = |addr_lo_i;
            SIZE_ILLEGAL: misaligned_o = 1'b1;
            default:      misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SIZE_BYTE: load_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            default:   load_data_o = rdata_i;
        endcase
    end

    // Untouched lanes come from the word read back during READ_WAIT.
    always_comb begin
        merge_data_o = wdata_i;
        case (size_i)
            SIZE_BYTE: merge_data_o = (merge_base_i & ~byte_mask) |
                                      (({24'b0, wdata_i[7:0]} << byte_sh) & byte_mask);
            SIZE_HALF: merge_data_o = (merge_base_i & ~half_mask) |
                                      (({16'b0, wdata_i[15:0]} << half_sh) & half_mask);
            default:   merge_data_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - single-outstanding load/store responder with read-modify-write
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [1:0]  addr_lo_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] mem_addr_q;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_mis_q, resp_mis_d;
    logic        accept, sample_rd, resp_load;

    logic        idle;
    logic [1:0]  lane_addr, lane_size;
    logic        lane_uns;
    logic [31:0] lane_wdata, load_data, merge_data;
    logic        lane_mis;

    // In IDLE the lane unit checks the live request; afterwards it works on the latched one.
    assign idle       = (state_q == IDLE);
    assign lane_addr  = idle ? req_addr[1:0] : addr_lo_q;
    assign lane_size  = idle ? req_size      : size_q;
    assign lane_uns   = idle ? req_unsigned  : uns_q;
    assign lane_wdata = idle ? req_wdata     : wdata_q;

    mem_lane_unit u_lane (
        .addr_lo_i    (lane_addr),
        .size_i       (lane_size),
        .unsigned_i   (lane_uns),
        .rdata_i      (mem_rdata),
        .merge_base_i (merge_q),
        .wdata_i      (lane_wdata),
        .load_data_o  (load_data),
        .merge_data_o (merge_data),
        .misaligned_o (lane_mis)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept       = 1'b0;
        sample_rd    = 1'b0;
        resp_load    = 1'b0;
        resp_rdata_d = 32'h0;
        resp_mis_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    cnt_d  = 3'd0;
                    if (lane_mis) begin
                        state_d    = RESP;
                        resp_load  = 1'b1;
                        resp_mis_d = 1'b1;
                    end else if (req_we && (req_size == SIZE_WORD)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ_WAIT;
                    end
                end
            end
            READ_WAIT: begin
                if (cnt_q == 3'(READ_LATENCY)) begin
                    sample_rd = 1'b1;
                    if (we_q) begin
                        state_d = WRITE;
                    end else begin
                        state_d      = RESP;
                        resp_load    = 1'b1;
                        resp_rdata_d = load_data;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            WRITE: begin
                state_d   = RESP;
                resp_load = 1'b1;
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            addr_lo_q    <= 2'b00;
            we_q         <= 1'b0;
            size_q       <= 2'b00;
            uns_q        <= 1'b0;
            wdata_q      <= 32'h0;
            merge_q      <= 32'h0;
            mem_addr_q   <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_lo_q  <= req_addr[1:0];
                we_q       <= req_we;
                size_q     <= req_size;
                uns_q      <= req_unsigned;
                wdata_q    <= req_wdata;
                mem_addr_q <= req_addr & WORD_ALIGN_MASK;
            end
            if (sample_rd) begin
                merge_q <= mem_rdata;
            end
            if (resp_load) begin
                resp_rdata_q <= resp_rdata_d;
                resp_mis_q   <= resp_mis_d;
            end
        end
    end

    assign req_ready       = idle;
    assign resp_valid      = (state_q == RESP);
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign mem_addr        = mem_addr_q;
    assign mem_wr          = (state_q == WRITE);
    assign mem_wdata       = mem_wr ? merge_data : 32'h0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        poke_en;
    logic [31:0] poke_addr, poke_data;

    logic        req_ready1, resp_valid1, resp_mis1, mem_wr1;
    logic [31:0] resp_rdata1, mem_addr1, mem_wdata1, mem_rdata1;
    logic        req_ready3, resp_valid3, resp_mis3, mem_wr3;
    logic [31:0] resp_rdata3, mem_addr3, mem_wdata3, mem_rdata3;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];

    int vectors = 0;
    int miscompares = 0;

    int          obs_lat, obs_nwr;
    logic [31:0] obs_wdata, obs_addr, obs_rdata;
    logic        obs_mis;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(req_ready1),
        .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
        .resp_misaligned(resp_mis1), .mem_addr(mem_addr1), .mem_wr(mem_wr1),
        .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    mem_access_unit #(.READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(req_ready3),
        .req_addr(req_addr), .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid3), .resp_rdata(resp_rdata3),
        .resp_misaligned(resp_mis3), .mem_addr(mem_addr3), .mem_wr(mem_wr3),
        .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3)
    );

    // Synchronous memories: read data appears READ_LATENCY edges after the address.
    always @(posedge clk) begin
        if (poke_en && !sel) mem1[poke_addr[11:2]] <= poke_data;
        else if (mem_wr1)    mem1[mem_addr1[11:2]] <= mem_wdata1;
        pipe1 <= mem1[mem_addr1[11:2]];
    end
    always @(posedge clk) begin
        if (poke_en && sel) mem3[poke_addr[11:2]] <= poke_data;
        else if (mem_wr3)   mem3[mem_addr3[11:2]] <= mem_wdata3;
        pipe3[0] <= mem3[mem_addr3[11:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign mem_rdata1 = pipe1;
    assign mem_rdata3 = pipe3[2];

    logic        req_ready_m, resp_valid_m, resp_mis_m, mem_wr_m;
    logic [31:0] resp_rdata_m, mem_addr_m, mem_wdata_m;
    assign req_ready_m  = sel ? req_ready3  : req_ready1;
    assign resp_valid_m = sel ? resp_valid3 : resp_valid1;
    assign resp_mis_m   = sel ? resp_mis3   : resp_mis1;
    assign mem_wr_m     = sel ? mem_wr3     : mem_wr1;
    assign resp_rdata_m = sel ? resp_rdata3 : resp_rdata1;
    assign mem_addr_m   = sel ? mem_addr3   : mem_addr1;
    assign mem_wdata_m  = sel ? mem_wdata3  : mem_wdata1;

    function automatic logic ref_mis(input logic [31:0] a, input logic [1:0] sz);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
        int unsigned v, nbits, lim;
        if (sz == 2'd2) return w;
        nbits = (sz == 2'd0) ? 8 : 16;
        lim   = 32'd1 << nbits;
        v     = (w >> (8 * (a % 4))) % lim;
        if (!uns && v >= lim / 2) v = v - lim;
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a,
                                              input logic [1:0] sz, input logic [31:0] wd);
        int unsigned nbits, sh, mask;
        if (sz == 2'd2) return wd;
        nbits = (sz == 2'd0) ? 8 : 16;
        sh    = 8 * (a % 4);
        mask  = ((32'd1 << nbits) - 1) << sh;
        return (old & ~mask) | ((wd % (32'd1 << nbits)) << sh);
    endfunction

    function automatic int ref_lat(input logic [31:0] a, input logic we, input logic [1:0] sz, input int rl);
        if (ref_mis(a, sz)) return 1;
        if (we && sz == 2'd2) return 2;
        if (!we) return rl + 2;
        return rl + 3;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Issues one request and records what the unit did until its response (bounded).
    task automatic run_req(input logic [31:0] a, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] wd);
        int budget;
        @(negedge clk);
        req_addr = a; req_we = we; req_size = sz; req_unsigned = uns; req_wdata = wd;
        req_valid = 1'b1;
        budget = 0;
        while (!req_ready_m && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        obs_lat = 0; obs_nwr = 0; obs_wdata = 32'h0; obs_rdata = 32'h0; obs_mis = 1'b0;
        obs_addr = mem_addr_m;
        for (int i = 1; i <= 40; i++) begin
            if (mem_wr_m) begin obs_nwr++; obs_wdata = mem_wdata_m; end
            if (resp_valid_m) begin
                obs_lat = i; obs_rdata = resp_rdata_m; obs_mis = resp_mis_m;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (req_ready_m !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", req_ready_m); end
        vectors++; if ({resp_valid_m, resp_mis_m, mem_wr_m} !== 3'b000) begin miscompares++; $display("FAIL reset_strobes: got %b want 000", {resp_valid_m, resp_mis_m, mem_wr_m}); end
        vectors++; if ({resp_rdata_m, mem_addr_m, mem_wdata_m} !== 96'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0", {resp_rdata_m, mem_addr_m, mem_wdata_m}); end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        vectors++; if ({req_ready_m, resp_valid_m} !== 2'b10) begin miscompares++; $display("FAIL reset_release: got %b want 10", {req_ready_m, resp_valid_m}); end
    endtask

    task automatic test_word_load();
        poke(32'h100, 32'hDEAD_BEEF);
        run_req(32'h100, 1'b0, 2'd2, 1'b0, 32'h0);
        vectors++; if (obs_addr !== 32'h100) begin miscompares++; $display("FAIL wload_addr: got %h want 00000100", obs_addr); end
        vectors++; if (obs_lat !== 3) begin miscompares++; $display("FAIL wload_lat: got %0d want 3", obs_lat); end
        vectors++; if ({obs_mis, obs_rdata} !== {1'b0, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL wload_data: got %b %h want 0 deadbeef", obs_mis, obs_rdata); end
        @(posedge clk); #1;
        vectors++; if ({resp_valid_m, resp_rdata_m} !== {1'b0, 32'hDEAD_BEEF}) begin miscompares++; $display("FAIL wload_hold: got %b %h want 0 deadbeef", resp_valid_m, resp_rdata_m); end
    endtask

    task automatic test_byte_loads();
        logic [31:0] a [0:4];
        logic [1:0]  s [0:4];
        logic        u [0:4];
        logic [31:0] e [0:4];
        a = '{32'h203, 32'h203, 32'h200, 32'h202, 32'h200};
        s = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
        u = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        e = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_0001, 32'hFFFF_80FF, 32'h0000_7F01};
        poke(32'h200, 32'h80FF_7F01);
        for (int k = 0; k < 5; k++) begin
            run_req(a[k], 1'b0, s[k], u[k], 32'h0);
            vectors++; if ({obs_lat, obs_mis, obs_rdata} !== {32'd3, 1'b0, e[k]}) begin miscompares++; $display("FAIL narrow_load_%0d: got lat %0d mis %b %h want 3 0 %h", k, obs_lat, obs_mis, obs_rdata, e[k]); end
        end
        run_req(32'h201, 1'b0, 2'd1, 1'b0, 32'h0);
        vectors++; if ({obs_lat, obs_mis, obs_rdata, obs_nwr} !== {32'd1, 1'b1, 32'h0, 32'd0}) begin miscompares++; $display("FAIL misaligned_half: got lat %0d mis %b %h wr %0d want 1 1 0 0", obs_lat, obs_mis, obs_rdata, obs_nwr); end
        run_req(32'h204, 1'b1, 2'd3, 1'b0, 32'hFFFF_FFFF);
        vectors++; if ({obs_lat, obs_mis, obs_nwr} !== {32'd1, 1'b1, 32'd0}) begin miscompares++; $display("FAIL illegal_size: got lat %0d mis %b wr %0d want 1 1 0", obs_lat, obs_mis, obs_nwr); end
    endtask

    task automatic test_partial_store();
        poke(32'h300, 32'h1122_3344);
        run_req(32'h302, 1'b1, 2'd0, 1'b0, 32'h5555_55AB);
        vectors++; if ({obs_lat, obs_nwr, obs_wdata} !== {32'd4, 32'd1, 32'h11AB_3344}) begin miscompares++; $display("FAIL store_byte: got lat %0d wr %0d %h want 4 1 11ab3344", obs_lat, obs_nwr, obs_wdata); end
        vectors++; if ({obs_mis, obs_rdata} !== 33'h0) begin miscompares++; $display("FAIL store_resp: got %b %h want 0 0", obs_mis, obs_rdata); end
        poke(32'h300, 32'h1122_3344);
        run_req(32'h300, 1'b1, 2'd1, 1'b0, 32'h7777_BEEF);
        vectors++; if ({obs_lat, obs_nwr, mem1[32'h300 >> 2]} !== {32'd4, 32'd1, 32'h1122_BEEF}) begin miscompares++; $display("FAIL store_half: got lat %0d wr %0d mem %h want 4 1 1122beef", obs_lat, obs_nwr, mem1[32'h300 >> 2]); end
    endtask

    task automatic test_back_to_back();
        int nwr, nresp, r1, r2;
        logic [2:0] rdy;
        int budget;
        @(negedge clk);
        req_addr = 32'h400; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_wdata = 32'hA5A5_0400; req_valid = 1'b1;
        budget = 0;
        while (!req_ready_m && budget < 50) begin @(negedge clk); budget++; end
        @(posedge clk); #1;
        req_addr = 32'h404; req_wdata = 32'h5A5A_0404;
        nwr = 0; nresp = 0; r1 = 0; r2 = 0; rdy = 3'b000;
        for (int i = 1; i <= 8; i++) begin
            if (mem_wr_m) nwr++;
            if (resp_valid_m) begin
                nresp++;
                if (nresp == 1) r1 = i; else r2 = i;
            end
            if (i <= 3) rdy[i-1] = req_ready_m;
            if (i == 4) req_valid = 1'b0;
            @(posedge clk); #1;
        end
        vectors++; if (rdy !== 3'b100) begin miscompares++; $display("FAIL b2b_ready: got %b want 100", rdy); end
        vectors++; if ({nwr, nresp, r1, r2} !== {32'd2, 32'd2, 32'd2, 32'd5}) begin miscompares++; $display("FAIL b2b_timing: got wr %0d resp %0d at %0d,%0d want 2 2 at 2,5", nwr, nresp, r1, r2); end
        vectors++; if ({mem1[32'h400 >> 2], mem1[32'h404 >> 2]} !== {32'hA5A5_0400, 32'h5A5A_0404}) begin miscompares++; $display("FAIL b2b_mem: got %h %h want a5a50400 5a5a0404", mem1[32'h400 >> 2], mem1[32'h404 >> 2]); end
    endtask

    task automatic test_reset_midop();
        int nwr, nresp, nrdy;
        int budget;
        poke(32'h500, 32'h5566_7788);
        @(negedge clk);
        req_addr = 32'h501; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_wdata = 32'h0000_00EE; req_valid = 1'b1;
        budget = 0;
        while (!req_ready_m && budget < 50) begin @(negedge clk); budget++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        vectors++; if ({req_ready_m, mem_wr_m, resp_valid_m} !== 3'b100) begin miscompares++; $display("FAIL midop_async: got %b want 100", {req_ready_m, mem_wr_m, resp_valid_m}); end
        repeat (2) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        nwr = 0; nresp = 0; nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (mem_wr_m) nwr++;
            if (resp_valid_m) nresp++;
            if (req_ready_m) nrdy++;
        end
        vectors++; if ({nwr, nresp, nrdy} !== {32'd0, 32'd0, 32'd8}) begin miscompares++; $display("FAIL midop_quiet: got wr %0d resp %0d ready %0d want 0 0 8", nwr, nresp, nrdy); end
        vectors++; if (mem1[32'h500 >> 2] !== 32'h5566_7788) begin miscompares++; $display("FAIL midop_mem: got %h want 55667788", mem1[32'h500 >> 2]); end
    endtask

    task automatic test_random();
        logic [31:0] a, wd, old, exp_rd, exp_mem;
        logic [1:0]  sz;
        logic        we, uns, mis;
        int          exp_nwr;
        for (int n = 0; n < 40; n++) begin
            a   = $urandom_range(0, 4095);
            sz  = 2'($urandom_range(0, 3));
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd  = $urandom;
            old = $urandom;
            poke(a, old);
            run_req(a, we, sz, uns, wd);
            mis     = ref_mis(a, sz);
            exp_nwr = (!mis && we) ? 1 : 0;
            exp_rd  = (!mis && !we) ? ref_load(old, a, sz, uns) : 32'h0;
            exp_mem = (exp_nwr == 1) ? ref_store(old, a, sz, wd) : old;
            vectors++; if ({obs_lat, obs_mis, obs_rdata} !== {ref_lat(a, we, sz, 1), mis, exp_rd}) begin miscompares++; $display("FAIL rand_resp_%0d: a %h sz %0d we %b got lat %0d mis %b %h want %0d %b %h", n, a, sz, we, obs_lat, obs_mis, obs_rdata, ref_lat(a, we, sz, 1), mis, exp_rd); end
            vectors++; if ({obs_nwr, mem1[a[11:2]]} !== {exp_nwr, exp_mem}) begin miscompares++; $display("FAIL rand_mem_%0d: a %h sz %0d we %b got wr %0d mem %h want %0d %h", n, a, sz, we, obs_nwr, mem1[a[11:2]], exp_nwr, exp_mem); end
        end
    endtask

    task automatic test_latency3();
        @(negedge clk); sel = 1'b1;
        poke(32'h100, 32'hCAFE_F00D);
        run_req(32'h100, 1'b0, 2'd2, 1'b0, 32'h0);
        vectors++; if ({obs_lat, obs_mis, obs_rdata} !== {32'd5, 1'b0, 32'hCAFE_F00D}) begin miscompares++; $display("FAIL rl3_load: got lat %0d mis %b %h want 5 0 cafef00d", obs_lat, obs_mis, obs_rdata); end
        run_req(32'h102, 1'b1, 2'd1, 1'b0, 32'h0000_1234);
        vectors++; if ({obs_lat, obs_nwr, mem3[32'h100 >> 2]} !== {32'd6, 32'd1, 32'h1234_F00D}) begin miscompares++; $display("FAIL rl3_store: got lat %0d wr %0d mem %h want 6 1 1234f00d", obs_lat, obs_nwr, mem3[32'h100 >> 2]); end
        run_req(32'h103, 1'b0, 2'd0, 1'b1, 32'h0);
        vectors++; if ({obs_lat, obs_rdata} !== {32'd5, 32'h0000_0012}) begin miscompares++; $display("FAIL rl3_byte: got lat %0d %h want 5 00000012", obs_lat, obs_rdata); end
    endtask

    initial begin
        reset = 1'b1; sel = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_we = 1'b0;
        req_size = 2'd0; req_unsigned = 1'b0; req_wdata = 32'h0;
        poke_en = 1'b0; poke_addr = 32'h0; poke_data = 32'h0;
        pipe1 = 32'h0; pipe3[0] = 32'h0; pipe3[1] = 32'h0; pipe3[2] = 32'h0;
        for (int i = 0; i < 1024; i++) begin mem1[i] = 32'h0; mem3[i] = 32'h0; end
        test_reset();
        test_word_load();
        test_byte_loads();
        test_partial_store();
        test_back_to_back();
        test_reset_midop();
        test_random();
        test_latency3();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
